// File: rtl/toggle_window_monitor.sv
// toggle_window_monitor
// Counts rising edges of sig_in over a fixed window of WINDOW clock cycles
// after a start pulse. It then reports whether the count fell inside
// [MIN_EDGES, MAX_EDGES]. The result stays visible until the next start or
// an abort. All outputs come straight from registers.
module toggle_window_monitor #(
  parameter int WINDOW    = 16,
  parameter int MIN_EDGES = 4,
  parameter int MAX_EDGES = 12,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edge_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] LastCycle = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] MinEdges  = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MaxEdges  = CNT_W'(MAX_EDGES);

  state_t           r_state;
  logic             r_sigQ;
  logic [CNT_W-1:0] r_cycleCnt;
  logic [CNT_W-1:0] r_edgeCount;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cycleCntNext;
  logic [CNT_W-1:0] w_edgeCountNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_passNext;
  logic             w_edge;
  logic [CNT_W-1:0] w_edgeSum;
  logic             w_inRange;

  // A rising edge is the current sample high while the previous one was low.
  // The count saturates at all-ones so that it never wraps back into the
  // passing range.
  assign w_edge    = sig_in & ~r_sigQ;
  assign w_edgeSum = (w_edge && (r_edgeCount != CntMax)) ?
                     (r_edgeCount + CNT_W'(1)) : r_edgeCount;
  assign w_inRange = (w_edgeSum >= MinEdges) && (w_edgeSum <= MaxEdges);

  // Next-state and next-output logic. Abort always beats start, and a start
  // arriving while a run is in progress is ignored.
  always_comb begin
    w_stateNext     = r_state;
    w_cycleCntNext  = r_cycleCnt;
    w_edgeCountNext = r_edgeCount;
    w_doneNext      = r_done;
    w_passNext      = r_pass;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_stateNext     = S_RUN;
          w_cycleCntNext  = '0;
          w_edgeCountNext = '0;
          w_doneNext      = 1'b0;
          w_passNext      = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_stateNext = S_IDLE;
          w_doneNext  = 1'b0;
          w_passNext  = 1'b0;
        end else begin
          w_cycleCntNext  = r_cycleCnt + CNT_W'(1);
          w_edgeCountNext = w_edgeSum;
          if (r_cycleCnt == LastCycle) begin
            w_stateNext = S_DONE;
            w_doneNext  = 1'b1;
            w_passNext  = w_inRange;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          w_stateNext = S_IDLE;
          w_doneNext  = 1'b0;
          w_passNext  = 1'b0;
        end else if (start) begin
          w_stateNext     = S_RUN;
          w_cycleCntNext  = '0;
          w_edgeCountNext = '0;
          w_doneNext      = 1'b0;
          w_passNext      = 1'b0;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_doneNext  = 1'b0;
        w_passNext  = 1'b0;
      end
    endcase
    w_busyNext = (w_stateNext == S_RUN);
  end

  // State and output registers. Reset clears everything, including a run in
  // flight, and no completion is reported for that run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sigQ      <= 1'b0;
      r_cycleCnt  <= '0;
      r_edgeCount <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_sigQ      <= sig_in;
      r_cycleCnt  <= w_cycleCntNext;
      r_edgeCount <= w_edgeCountNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
      r_pass      <= w_passNext;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign edge_count = r_edgeCount;

endmodule

// File: tb/tb_toggle_window_monitor.sv
// Testbench for toggle_window_monitor.
// Four instances cover the default range, a narrowed maximum, a 3-bit counter
// with a wide-open range, and a 3-bit counter with a single-value range.
// Each completed measurement is scored against a queue of hand-computed
// results.
module tb_toggle_window_monitor;

  localparam int N = 4;

  typedef struct {
    int dut;
    int count;
    int passV;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic [N-1:0] sigIn;
  logic [N-1:0] startP;
  logic [N-1:0] abortP;
  logic [N-1:0] busy;
  logic [N-1:0] done;
  logic [N-1:0] pass;
  logic [7:0]   cntA;
  logic [7:0]   cntB;
  logic [2:0]   cntC;
  logic [2:0]   cntD;

  int   assertions = 0;
  int   failures   = 0;
  exp_t scoreQ[$];
  exp_t monExp;
  logic [N-1:0] prevDone = '0;

  // 10-time-unit clock
  always #5 clk = ~clk;

  toggle_window_monitor dutA (
    .clk(clk), .rst_n(rstN), .sig_in(sigIn[0]), .start(startP[0]), .abort(abortP[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .edge_count(cntA)
  );

  toggle_window_monitor #(.WINDOW(16), .MIN_EDGES(4), .MAX_EDGES(6), .CNT_W(8)) dutB (
    .clk(clk), .rst_n(rstN), .sig_in(sigIn[1]), .start(startP[1]), .abort(abortP[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .edge_count(cntB)
  );

  toggle_window_monitor #(.WINDOW(7), .MIN_EDGES(0), .MAX_EDGES(7), .CNT_W(3)) dutC (
    .clk(clk), .rst_n(rstN), .sig_in(sigIn[2]), .start(startP[2]), .abort(abortP[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .edge_count(cntC)
  );

  toggle_window_monitor #(.WINDOW(7), .MIN_EDGES(3), .MAX_EDGES(3), .CNT_W(3)) dutD (
    .clk(clk), .rst_n(rstN), .sig_in(sigIn[3]), .start(startP[3]), .abort(abortP[3]),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .edge_count(cntD)
  );

  function automatic int getCnt(input int d);
    case (d)
      0:       return int'(cntA);
      1:       return int'(cntB);
      2:       return int'(cntC);
      default: return int'(cntD);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    assertions++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full measurement on instance d. The value of sig_in at the start
  // edge is startSig. It either toggles every cycle or holds for the window.
  // restartAt > 0 pulses start again that many cycles into the run.
  task automatic applyStimulus(input int d, input int window, input logic startSig,
                               input logic toggle, input int restartAt,
                               input int expCount, input int expPass);
    exp_t e;
    logic cur;
    e.dut = d;
    e.count = expCount;
    e.passV = expPass;
    scoreQ.push_back(e);
    cur = startSig;
    sigIn[d]  = startSig;
    startP[d] = 1'b1;
    tick();
    startP[d] = 1'b0;
    checkOutput("startBusy", int'(busy[d]), 1);
    checkOutput("startDoneLow", int'(done[d]), 0);
    checkOutput("startCnt", getCnt(d), 0);
    for (int i = 1; i <= window; i++) begin
      if (toggle) cur = ~cur;
      sigIn[d]  = cur;
      startP[d] = (i == restartAt);
      checkOutput("runBusyDone", int'({busy[d], done[d]}), 2);
      tick();
    end
    startP[d] = 1'b0;
    checkOutput("endBusy", int'(busy[d]), 0);
    checkOutput("endDone", int'(done[d]), 1);
  endtask

  // Monitor: every rising edge of done pops one expected result
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (done[d] === 1'b1 && prevDone[d] !== 1'b1) begin
        if (scoreQ.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpectedDone: dut %0d raised done, expected no completion", d);
        end else begin
          monExp = scoreQ.pop_front();
          checkOutput("doneDut", d, monExp.dut);
          checkOutput("doneCount", getCnt(d), monExp.count);
          checkOutput("donePass", int'(pass[d]), monExp.passV);
        end
      end
    end
    prevDone <= done;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rstN   = 1'b0;
    sigIn  = '0;
    startP = '0;
    abortP = '0;
    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      checkOutput("resetFlags", int'({busy[d], done[d], pass[d]}), 0);
      checkOutput("resetCnt", getCnt(d), 0);
    end
    rstN = 1'b1;
    repeat (6) tick();

    // Alternating input: 8 edges, in range
    applyStimulus(0, 16, 1'b0, 1'b1, 0, 8, 1);
    repeat (2) tick();

    // Constant input, high then low: no edges, fails
    applyStimulus(0, 16, 1'b1, 1'b0, 0, 0, 0);
    applyStimulus(0, 16, 1'b0, 1'b0, 0, 0, 0);

    // Narrowed max: 8 edges fail, then a back-to-back restart from DONE
    applyStimulus(1, 16, 1'b0, 1'b1, 0, 8, 0);
    applyStimulus(1, 16, 1'b0, 1'b1, 0, 8, 0);

    // Abort five cycles into a run; count holds at 3
    sigIn[0]  = 1'b0;
    startP[0] = 1'b1;
    tick();
    startP[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sigIn[0] = i[0];
      tick();
    end
    sigIn[0]  = 1'b0;
    abortP[0] = 1'b1;
    tick();
    abortP[0] = 1'b0;
    checkOutput("abortFlags", int'({busy[0], done[0], pass[0]}), 0);
    checkOutput("abortCnt", getCnt(0), 3);
    startP[0] = 1'b1;
    abortP[0] = 1'b1;
    tick();
    startP[0] = 1'b0;
    abortP[0] = 1'b0;
    checkOutput("startAbortBusy", int'({busy[0], done[0]}), 0);
    tick();
    checkOutput("startAbortIdle", int'({busy[0], done[0]}), 0);

    // Reset in the middle of a run clears everything
    sigIn[0]  = 1'b0;
    startP[0] = 1'b1;
    tick();
    startP[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sigIn[0] = i[0];
      tick();
    end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("midResetFlags", int'({busy[0], done[0], pass[0]}), 0);
    checkOutput("midResetCnt", getCnt(0), 0);
    tick();

    // Start during a run is ignored; done timing unchanged
    applyStimulus(0, 16, 1'b0, 1'b1, 5, 8, 1);

    // 3-bit counter, window 7, open range: 3 then 4 edges
    applyStimulus(2, 7, 1'b1, 1'b1, 0, 3, 1);
    applyStimulus(2, 7, 1'b0, 1'b1, 0, 4, 1);

    // Single-value range [3,3]: exactly 3 passes, 4 fails
    applyStimulus(3, 7, 1'b1, 1'b1, 0, 3, 1);
    applyStimulus(3, 7, 1'b0, 1'b1, 0, 4, 0);

    repeat (2) tick();
    checkOutput("queueEmpty", scoreQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
